// File: rtl/parking_space_manager.sv
// Parking space allocator: grants the lowest free space to a waiting car and frees spaces on exit.
// Optional sticky illegal-exit flag on err when PARK_SPACE_ERR_EN is defined.
module parking_space_manager (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_valid,
  input  logic [2:0] exit_space,
  input  logic [2:0] park_number,
  output logic [7:0] parking_capacity,
  output logic       enable,
  output logic       entry_ack,
  output logic [2:0] assigned_space,
  output logic [3:0] free_count,
  output logic       full,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StLookup, StAlloc} state_e;

  state_e     state;
  logic       exit_legal;
  logic       alloc_hit;
  logic [7:0] cap_next;
  logic [3:0] count_next;

  // Exit legality uses the pre-edge map, so an exit naming the space being allocated is illegal.
  always_comb begin
    exit_legal = exit_valid && !parking_capacity[exit_space];
    alloc_hit  = (state == StAlloc) && parking_capacity[assigned_space];
    cap_next   = parking_capacity;
    if (alloc_hit) cap_next[assigned_space] = 1'b0;
    if (exit_legal) cap_next[exit_space] = 1'b1;
    count_next = free_count + {3'b000, exit_legal} - {3'b000, alloc_hit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= StIdle;
      parking_capacity <= 8'hFF;
      free_count       <= 4'd8;
      assigned_space   <= 3'd0;
    end else begin
      parking_capacity <= cap_next;
      free_count       <= count_next;
      case (state)
        StIdle: begin
          if (entry_req && !full) state <= StLookup;
        end
        StLookup: begin
          assigned_space <= park_number;
          state          <= StAlloc;
        end
        StAlloc: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign full      = (free_count == 4'd0);
  assign enable    = (state == StLookup);
  assign entry_ack = (state == StAlloc);

`ifdef PARK_SPACE_ERR_EN
  logic exit_illegal;
  assign exit_illegal = exit_valid && parking_capacity[exit_space];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (exit_illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_parking_space_manager.sv
// Scoreboard bench for parking_space_manager: directed scenarios followed by random traffic,
// checked against a set-of-free-spaces reference model.
module tb_parking_space_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_valid = 1'b0;
  logic [2:0] exit_space = 3'd0;
  logic [2:0] park_number;
  logic [7:0] parking_capacity;
  logic       enable;
  logic       entry_ack;
  logic [2:0] assigned_space;
  logic [3:0] free_count;
  logic       full;
  logic       err;

`ifdef PARK_SPACE_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  parking_space_manager dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .entry_req        (entry_req),
    .exit_valid       (exit_valid),
    .exit_space       (exit_space),
    .park_number      (park_number),
    .parking_capacity (parking_capacity),
    .enable           (enable),
    .entry_ack        (entry_ack),
    .assigned_space   (assigned_space),
    .free_count       (free_count),
    .full             (full),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Downstream priority encoder: lowest free space.
  always_comb begin
    park_number = 3'd0;
    for (int i = 7; i >= 0; i--) if (parking_capacity[i]) park_number = i[2:0];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: set of free spaces plus grant timing by edge number.
  bit   m_free[8];
  int   cyc, next_ok, lookup_at, grant_at, pend;
  bit   m_err, exp_en, exp_ack;
  int   exp_q[$];

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_free[i];
    return n;
  endfunction

  function automatic logic [7:0] m_map();
    logic [7:0] m = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = m_free[i];
    return m;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < 8; i++) if (m_free[i]) return i;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) m_free[i] = 1'b1;
        cyc = 0; next_ok = 0; lookup_at = -10; grant_at = -10; pend = 0;
        m_err = 1'b0; exp_en = 1'b0; exp_ack = 1'b0;
        exp_q.delete();
      end else begin
        automatic bit legal = exit_valid && !m_free[exit_space];
        automatic bit accept = (cyc >= next_ok) && entry_req && (m_count() > 0);
        if (cyc == lookup_at) begin
          pend = m_lowest();
          exp_q.push_back(pend);
        end
        if (cyc == grant_at) m_free[pend] = 1'b0;
        if (legal) m_free[exit_space] = 1'b1;
        else if (exit_valid && ErrEn) m_err = 1'b1;
        if (accept) begin
          lookup_at = cyc + 1;
          grant_at  = cyc + 2;
          next_ok   = cyc + 3;
        end
        exp_en  = (lookup_at == cyc + 1);
        exp_ack = (grant_at == cyc + 1);
        cyc++;
      end
    end
  end

  // Monitor: compares every cycle and pops the scoreboard on each grant.
  initial begin
    forever begin
      @(negedge clk);
      chk("map", parking_capacity, m_map());
      chk("free_count", free_count, m_count());
      chk("full", full, (m_count() == 0));
      chk("enable", enable, exp_en);
      chk("entry_ack", entry_ack, exp_ack);
      chk("err", err, m_err);
      if (entry_ack === 1'b1) begin
        if (exp_q.size() == 0) chk("ack_unexpected", entry_ack, 0);
        else chk("assigned_space", assigned_space, exp_q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    chk("rst_map", parking_capacity, 8'hFF);
    chk("rst_count", free_count, 8);
    chk("rst_asg", assigned_space, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    entry_req = 1'b1;
    step(1);
    chk("first_enable", enable, 1);
    step(1);
    chk("first_ack", entry_ack, 1);
    chk("first_asg", assigned_space, 0);
    step(1);
    chk("first_map", parking_capacity, 8'hFE);
    chk("first_count", free_count, 7);
    step(21);
    chk("full_map", parking_capacity, 8'h00);
    chk("full_flag", full, 1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("full_no_ack", entry_ack, 0);
    end
    // Exit while full with the request still waiting.
    exit_valid = 1'b1;
    exit_space = 3'd5;
    step(1);
    exit_valid = 1'b0;
    chk("exit5_map", parking_capacity, 8'h20);
    step(1);
    chk("exit5_enable", enable, 1);
    step(1);
    chk("exit5_ack", entry_ack, 1);
    chk("exit5_asg", assigned_space, 5);
    entry_req = 1'b0;
    step(1);
    chk("exit5_full", parking_capacity, 8'h00);
    // Map 8'h01, then exit of space 2 coinciding with ALLOC of space 0.
    exit_valid = 1'b1;
    exit_space = 3'd0;
    step(1);
    exit_valid = 1'b0;
    chk("one_free_map", parking_capacity, 8'h01);
    entry_req = 1'b1;
    step(1);
    entry_req = 1'b0;
    step(1);
    chk("alloc_ack", entry_ack, 1);
    exit_valid = 1'b1;
    exit_space = 3'd2;
    step(1);
    exit_valid = 1'b0;
    chk("alloc_exit_map", parking_capacity, 8'h04);
    chk("alloc_exit_count", free_count, 1);
    // Reset during LOOKUP.
    entry_req = 1'b1;
    step(1);
    entry_req = 1'b0;
    chk("pre_rst_enable", enable, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", entry_ack, 0);
    chk("mid_rst_map", parking_capacity, 8'hFF);
    chk("mid_rst_count", free_count, 8);
    step(1);
    rst_n = 1'b1;
    // Illegal exit on all-free map.
    exit_valid = 1'b1;
    exit_space = 3'd3;
    step(1);
    exit_valid = 1'b0;
    chk("illegal_map", parking_capacity, 8'hFF);
    chk("illegal_count", free_count, 8);
    chk("illegal_err", err, ErrEn);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      entry_req  = ($urandom_range(0, 9) < 6);
      exit_valid = ($urandom_range(0, 9) < 4);
      exit_space = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
    end
    entry_req = 1'b0;
    exit_valid = 1'b0;
    step(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
